// File: rtl/lsu_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module : lsu_mem_ctrl                                            |
// | Desc   : Load/store sequencer between execute stage and memory   |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [1:0]  rsp_err
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic [1:0] c_err_ok  = 2'b00;
    localparam logic [1:0] c_err_mis = 2'b01;
    localparam logic [1:0] c_err_ill = 2'b10;
    localparam logic [1:0] c_err_tmo = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_funct3;
    logic [1:0]       r_lane;
    logic             r_store;
    logic [4:0]       r_rd;

    logic             w_accept;
    logic             w_active;
    logic             w_done;
    logic             w_tmo;
    logic             w_illegal;
    logic             w_misal;
    logic [1:0]       w_req_err;
    logic [31:0]      w_st_wdata;
    logic [3:0]       w_st_wstrb;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ld_data;

    assign req_ready = (r_state == c_st_idle);
    assign w_accept  = req_valid && req_ready;
    assign w_active  = (r_state == c_st_issue) || (r_state == c_st_wait);
    // A grant and completion in the same ISSUE cycle skips WAIT entirely.
    assign w_done    = mem_rvalid && (((r_state == c_st_issue) && mem_gnt) || (r_state == c_st_wait));
    assign w_tmo     = w_active && !w_done && (r_cnt == c_cnt_last);

    always_comb begin
        w_illegal = req_store ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                              : ((req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110));
        w_misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        w_req_err = c_err_ok;
        if (w_illegal) begin
            w_req_err = c_err_ill;
        end else if (w_misal) begin
            w_req_err = c_err_mis;
        end

        w_st_wdata = 32'd0;
        w_st_wstrb = 4'b0000;
        if (req_store) begin
            case (req_funct3[1:0])
                2'b00: begin
                    w_st_wdata = {4{req_wdata[7:0]}};
                    w_st_wstrb = 4'b0001 << req_addr[1:0];
                end
                2'b01: begin
                    w_st_wdata = {2{req_wdata[15:0]}};
                    w_st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_st_wdata = req_wdata;
                    w_st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = (w_req_err != c_err_ok) ? c_st_resp : c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_done || w_tmo) begin
                    w_next_state = c_st_resp;
                end else if (mem_gnt) begin
                    w_next_state = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_done || w_tmo) begin
                    w_next_state = c_st_resp;
                end
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_funct3  <= 3'd0;
            r_lane    <= 2'd0;
            r_store   <= 1'b0;
            r_rd      <= 5'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_rd    <= 5'd0;
            rsp_err   <= 2'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_funct3 <= req_funct3;
                        r_lane   <= req_addr[1:0];
                        r_store  <= req_store;
                        r_rd     <= req_rd;
                        if (w_req_err != c_err_ok) begin
                            // Rejected requests never reach the memory port.
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'd0;
                            rsp_rd    <= req_rd;
                            rsp_err   <= w_req_err;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= w_st_wdata;
                            mem_wstrb <= w_st_wstrb;
                        end
                    end
                end
                c_st_issue, c_st_wait: begin
                    if ((r_state == c_st_issue) && mem_gnt) begin
                        mem_req <= 1'b0;
                    end
                    if (w_done) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= r_store ? 32'd0 : w_ld_data;
                        rsp_rd    <= r_rd;
                        rsp_err   <= c_err_ok;
                    end else if (w_tmo) begin
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'd0;
                        rsp_rd    <= r_rd;
                        rsp_err   <= c_err_tmo;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_lsu_mem_ctrl                                         |
// | Desc   : Scoreboard bench for the load/store sequencer           |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT_CYC = 256;
    localparam int CNT_W       = 9;
    localparam int MAX_WAIT    = 400;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic        req_store  = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr   = 32'd0;
    logic [31:0] req_wdata  = 32'd0;
    logic [4:0]  req_rd     = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt    = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata  = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic        got;
        int          lat;
        logic        saw_req;
        int          req_cycles;
        logic        stable;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic        ready_at_rsp;
    } obs_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Presents one request, plays the memory side, and returns in the first cycle rsp_valid is seen.
    task automatic drive_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                             input int gnt_delay, input logic same_cyc, input logic no_rvalid,
                             output obs_t o);
        int   gcnt;
        logic granted;
        o.got = 1'b0; o.lat = 0; o.saw_req = 1'b0; o.req_cycles = 0; o.stable = 1'b1;
        o.addr = 32'd0; o.wdata = 32'd0; o.wstrb = 4'd0; o.we = 1'b0; o.ready_at_rsp = 1'b0;
        gcnt = 0;
        granted = 1'b0;
        req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = rdata;
            if (rsp_valid) begin
                o.got = 1'b1;
                o.lat = cyc;
                o.ready_at_rsp = req_ready;
                break;
            end
            if (granted && !no_rvalid) mem_rvalid = 1'b1;
            granted = 1'b0;
            if (mem_req) begin
                if (!o.saw_req) begin
                    o.saw_req = 1'b1;
                    o.addr = mem_addr; o.wdata = mem_wdata; o.wstrb = mem_wstrb; o.we = mem_we;
                end else if (mem_addr !== o.addr || mem_wdata !== o.wdata ||
                             mem_wstrb !== o.wstrb || mem_we !== o.we) begin
                    o.stable = 1'b0;
                end
                o.req_cycles = o.req_cycles + 1;
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    if (same_cyc && !no_rvalid) mem_rvalid = 1'b1;
                    else granted = 1'b1;
                end else begin
                    gcnt = gcnt + 1;
                end
            end
            tick();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== 69'd0) begin
            failures++; $display("FAIL reset_mem_fields got=%h/%h/%h/%b exp=0", mem_addr, mem_wdata, mem_wstrb, mem_we); end
        checks++; if ({rsp_data, rsp_rd, rsp_err} !== 39'd0) begin
            failures++; $display("FAIL reset_rsp_fields got=%h/%h/%h exp=0", rsp_data, rsp_rd, rsp_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_lanes();
        logic [2:0]  f3 [9] = '{3'b000, 3'b000, 3'b001, 3'b101, 3'b010, 3'b100, 3'b000, 3'b001, 3'b000};
        logic [31:0] ad [9] = '{32'h00100002, 32'h00100002, 32'h00100002, 32'h00100002, 32'h00100004,
                               32'h00100003, 32'h00100001, 32'h00100000, 32'h00100003};
        logic [31:0] rv [9] = '{32'hFFFFFFF0, 32'hFF7FFFF0, 32'hFF7FFFF0, 32'hFF7FFFF0, 32'h12345678,
                               32'h80563412, 32'h80563412, 32'h12348765, 32'h80563412};
        logic [31:0] ex [9] = '{32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFF7F, 32'h0000FF7F, 32'h12345678,
                               32'h00000080, 32'h00000034, 32'hFFFF8765, 32'hFFFFFF80};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{data: ex[i], rd: 5'(i + 1), err: 2'b00});
            drive_txn(1'b0, f3[i], ad[i], 32'h0, 5'(i + 1), rv[i], 0, 1'b0, 1'b0, o);
            e = sb.pop_front();
            checks++; if (o.got !== 1'b1) begin failures++; $display("FAIL load%0d_no_rsp got=%b exp=1", i, o.got); end
            checks++; if (o.lat !== 3) begin failures++; $display("FAIL load%0d_latency got=%0d exp=3", i, o.lat); end
            checks++; if (o.addr !== (ad[i] & 32'hFFFF_FFFC)) begin
                failures++; $display("FAIL load%0d_mem_addr got=%h exp=%h", i, o.addr, ad[i] & 32'hFFFF_FFFC); end
            checks++; if ({o.we, o.wstrb} !== 5'b0) begin failures++; $display("FAIL load%0d_we_wstrb got=%b%b exp=00000", i, o.we, o.wstrb); end
            checks++; if (rsp_data !== e.data) begin failures++; $display("FAIL load%0d_data got=%h exp=%h", i, rsp_data, e.data); end
            checks++; if ({rsp_rd, rsp_err} !== {e.rd, e.err}) begin
                failures++; $display("FAIL load%0d_rd_err got=%h/%b exp=%h/%b", i, rsp_rd, rsp_err, e.rd, e.err); end
            ack_rsp();
        end
    endtask

    task automatic test_stores();
        logic [31:0] ad [5] = '{32'h00000001, 32'h00000003, 32'h00000006, 32'h00000010, 32'h00000008};
        logic [2:0]  f3 [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        logic [31:0] wd [5] = '{32'h000000AB, 32'h12345678, 32'h1234CAFE, 32'h0000BEEF, 32'hDEADBEEF};
        logic [31:0] xw [5] = '{32'hABABABAB, 32'h78787878, 32'hCAFECAFE, 32'hBEEFBEEF, 32'hDEADBEEF};
        logic [3:0]  xs [5] = '{4'b0010, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{data: 32'h0, rd: 5'(i + 16), err: 2'b00});
            drive_txn(1'b1, f3[i], ad[i], wd[i], 5'(i + 16), 32'hFFFFFFFF, 0, 1'b0, 1'b0, o);
            e = sb.pop_front();
            checks++; if (o.got !== 1'b1) begin failures++; $display("FAIL store%0d_no_rsp got=%b exp=1", i, o.got); end
            checks++; if (o.we !== 1'b1) begin failures++; $display("FAIL store%0d_we got=%b exp=1", i, o.we); end
            checks++; if (o.addr !== (ad[i] & 32'hFFFF_FFFC)) begin
                failures++; $display("FAIL store%0d_mem_addr got=%h exp=%h", i, o.addr, ad[i] & 32'hFFFF_FFFC); end
            checks++; if (o.wdata !== xw[i]) begin failures++; $display("FAIL store%0d_wdata got=%h exp=%h", i, o.wdata, xw[i]); end
            checks++; if (o.wstrb !== xs[i]) begin failures++; $display("FAIL store%0d_wstrb got=%b exp=%b", i, o.wstrb, xs[i]); end
            checks++; if ({rsp_data, rsp_rd, rsp_err} !== {e.data, e.rd, e.err}) begin
                failures++; $display("FAIL store%0d_rsp got=%h/%h/%b exp=%h/%h/%b", i, rsp_data, rsp_rd, rsp_err, e.data, e.rd, e.err); end
            ack_rsp();
        end
    endtask

    task automatic test_errors();
        logic        st [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3 [9] = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b110, 3'b100, 3'b011};
        logic [31:0] ad [9] = '{32'h00100002, 32'h00100001, 32'h00100003, 32'h00000002, 32'h00000001,
                               32'h00100000, 32'h00100000, 32'h00000000, 32'h00000000};
        logic [1:0]  xe [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{data: 32'h0, rd: 5'(i + 3), err: xe[i]});
            drive_txn(st[i], f3[i], ad[i], 32'h5555AAAA, 5'(i + 3), 32'h12345678, 0, 1'b0, 1'b0, o);
            e = sb.pop_front();
            checks++; if (o.got !== 1'b1 || o.lat > 3) begin
                failures++; $display("FAIL err%0d_rsp_timing got=%b/%0d exp=1/<=3", i, o.got, o.lat); end
            checks++; if (o.saw_req !== 1'b0) begin failures++; $display("FAIL err%0d_mem_req got=%b exp=0", i, o.saw_req); end
            checks++; if ({rsp_data, rsp_rd, rsp_err} !== {e.data, e.rd, e.err}) begin
                failures++; $display("FAIL err%0d_rsp got=%h/%h/%b exp=%h/%h/%b", i, rsp_data, rsp_rd, rsp_err, e.data, e.rd, e.err); end
            ack_rsp();
        end
    endtask

    task automatic test_stall();
        obs_t o;
        exp_t e;
        sb.push_back('{data: 32'hA5A50F0F, rd: 5'd7, err: 2'b00});
        drive_txn(1'b0, 3'b010, 32'h00100008, 32'h0, 5'd7, 32'hA5A50F0F, 3, 1'b0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.stable !== 1'b1) begin failures++; $display("FAIL stall_mem_stable got=%b exp=1", o.stable); end
        checks++; if (o.req_cycles !== 4) begin failures++; $display("FAIL stall_req_cycles got=%0d exp=4", o.req_cycles); end
        checks++; if (o.lat !== 6) begin failures++; $display("FAIL stall_latency got=%0d exp=6", o.lat); end
        for (int k = 0; k < 3; k++) begin
            checks++; if ({rsp_valid, rsp_data, rsp_rd, rsp_err} !== {1'b1, e.data, e.rd, e.err}) begin
                failures++; $display("FAIL stall_rsp_hold%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", k, rsp_valid,
                                     rsp_data, rsp_rd, rsp_err, e.data, e.rd, e.err); end
            if (k < 2) tick();
        end
        ack_rsp();
        for (int k = 0; k < 3; k++) begin
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_single_rsp%0d got=%b exp=0", k, rsp_valid); end
            tick();
        end
    endtask

    task automatic test_gnt_rvalid_same();
        obs_t o;
        exp_t e;
        sb.push_back('{data: 32'h0000ABCD, rd: 5'd12, err: 2'b00});
        drive_txn(1'b0, 3'b101, 32'h00100002, 32'h0, 5'd12, 32'hABCD1234, 0, 1'b1, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.lat !== 2) begin failures++; $display("FAIL same_cycle_latency got=%0d exp=2", o.lat); end
        checks++; if ({rsp_data, rsp_rd, rsp_err} !== {e.data, e.rd, e.err}) begin
            failures++; $display("FAIL same_cycle_rsp got=%h/%h/%b exp=%h/%h/%b", rsp_data, rsp_rd, rsp_err, e.data, e.rd, e.err); end
        ack_rsp();
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        sb.push_back('{data: 32'hCAFEF00D, rd: 5'd20, err: 2'b00});
        sb.push_back('{data: 32'h000000FE, rd: 5'd21, err: 2'b00});
        drive_txn(1'b0, 3'b010, 32'h00200000, 32'h0, 5'd20, 32'hCAFEF00D, 0, 1'b0, 1'b0, o);
        e = sb.pop_front();
        checks++; if (o.ready_at_rsp !== 1'b0) begin failures++; $display("FAIL b2b_ready_in_resp got=%b exp=0", o.ready_at_rsp); end
        checks++; if ({rsp_data, rsp_rd} !== {e.data, e.rd}) begin
            failures++; $display("FAIL b2b_first got=%h/%h exp=%h/%h", rsp_data, rsp_rd, e.data, e.rd); end
        ack_rsp();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after got=%b exp=1", req_ready); end
        drive_txn(1'b0, 3'b100, 32'h00200001, 32'h0, 5'd21, 32'h1234FE00, 0, 1'b0, 1'b0, o);
        e = sb.pop_front();
        checks++; if ({rsp_data, rsp_rd, rsp_err} !== {e.data, e.rd, e.err}) begin
            failures++; $display("FAIL b2b_second got=%h/%h/%b exp=%h/%h/%b", rsp_data, rsp_rd, rsp_err, e.data, e.rd, e.err); end
        ack_rsp();
    endtask

    task automatic test_timeout();
        obs_t o;
        exp_t e;
        // Granted, but no completion ever arrives.
        sb.push_back('{data: 32'h0, rd: 5'd9, err: 2'b11});
        drive_txn(1'b0, 3'b010, 32'h00100010, 32'h0, 5'd9, 32'h77777777, 0, 1'b0, 1'b1, o);
        e = sb.pop_front();
        checks++; if (o.got !== 1'b1 || o.lat < TIMEOUT_CYC || o.lat > TIMEOUT_CYC + 2) begin
            failures++; $display("FAIL timeout_wait_latency got=%b/%0d exp=1/%0d..%0d", o.got, o.lat, TIMEOUT_CYC, TIMEOUT_CYC + 2); end
        checks++; if ({rsp_data, rsp_rd, rsp_err, mem_req} !== {e.data, e.rd, e.err, 1'b0}) begin
            failures++; $display("FAIL timeout_wait_rsp got=%h/%h/%b/%b exp=%h/%h/%b/0", rsp_data, rsp_rd, rsp_err, mem_req, e.data, e.rd, e.err); end
        ack_rsp();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin
            failures++; $display("FAIL timeout_stray_rvalid got=%b%b exp=01", rsp_valid, req_ready); end
        // Never granted: mem_req must be withdrawn on timeout.
        sb.push_back('{data: 32'h0, rd: 5'd10, err: 2'b11});
        drive_txn(1'b1, 3'b010, 32'h00100014, 32'h11223344, 5'd10, 32'h0, 100000, 1'b0, 1'b1, o);
        e = sb.pop_front();
        checks++; if (o.got !== 1'b1 || o.req_cycles < TIMEOUT_CYC - 1 || o.req_cycles > TIMEOUT_CYC + 1) begin
            failures++; $display("FAIL timeout_issue_req_cycles got=%b/%0d exp=1/~%0d", o.got, o.req_cycles, TIMEOUT_CYC); end
        checks++; if ({rsp_data, rsp_rd, rsp_err, mem_req} !== {e.data, e.rd, e.err, 1'b0}) begin
            failures++; $display("FAIL timeout_issue_rsp got=%h/%h/%b/%b exp=%h/%h/%b/0", rsp_data, rsp_rd, rsp_err, mem_req, e.data, e.rd, e.err); end
        ack_rsp();
    endtask

    task automatic test_reset_mid();
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h00100010; req_rd = 5'd5;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h00100010}) begin
            failures++; $display("FAIL rstmid_issue got=%b/%h exp=1/00100010", mem_req, mem_addr); end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b000) begin
            failures++; $display("FAIL rstmid_wait got=%b%b%b exp=000", mem_req, rsp_valid, req_ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, mem_req, rsp_valid, mem_addr} !== {3'b100, 32'h0}) begin
            failures++; $display("FAIL rstmid_async got=%b%b%b/%h exp=100/00000000", req_ready, mem_req, rsp_valid, mem_addr); end
        #1 rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEADDEAD;
        tick();
        mem_rvalid = 1'b0;
        tick();
        checks++; if ({rsp_valid, req_ready} !== 2'b01) begin
            failures++; $display("FAIL rstmid_no_rsp got=%b%b exp=01", rsp_valid, req_ready); end
    endtask

    initial begin
        test_reset();
        test_load_lanes();
        test_stores();
        test_errors();
        test_stall();
        test_gnt_rvalid_same();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
